// File: rtl/yacc_pkg.sv
// Shared definitions for the YACC access scheduler: address field positions and FSM encoding.
package yacc_pkg;

   localparam int unsigned TAG_LSB = 11;
   localparam int unsigned SET_LSB = 8;
   localparam int unsigned BLK_LSB = 6;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLookup = 2'd1,
      StFill   = 2'd2,
      StResp   = 2'd3
   } state_e;

endpackage

// File: rtl/yacc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module yacc_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int unsigned cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(ptr) + k) % NUM_REQ;
         if (!any && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/yacc_access_scheduler.sv
// Shares the single YACC cache lookup port among NUM_REQ requesters; one access in flight,
// round-robin grant, lookup / miss fill / response sequencing and saturating hit/miss counters.
module yacc_access_scheduler
   import yacc_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic                      resp_hit,
   output logic [ADDR_W-1:0]         cache_addr,
   output logic                      cache_lookup,
   input  logic                      cache_done,
   input  logic                      cache_hit,
   output logic                      fill_start,
   input  logic                      fill_done,
   output logic [CNT_W-1:0]          hit_count,
   output logic [CNT_W-1:0]          miss_count
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 lookup_q, lookup_d;
   logic                 fill_q, fill_d;
   logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
   logic                 resp_hit_q, resp_hit_d;
   logic [CNT_W-1:0]     hit_q, hit_d;
   logic [CNT_W-1:0]     miss_q, miss_d;

   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_any;
   logic [ADDR_W-1:0]    sel_addr;

   yacc_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // Ready is the arbiter pick, only offered while idle.
   assign req_ready = (state_q == StIdle) ? grant : '0;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      lookup_d     = 1'b0;
      fill_d       = 1'b0;
      resp_valid_d = '0;
      resp_hit_d   = 1'b0;
      hit_d        = hit_q;
      miss_d       = miss_q;
      sel_addr     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
      unique case (state_q)
         StIdle: begin
            if (grant_any) begin
               state_d  = StLookup;
               idx_d    = grant_idx;
               addr_d   = sel_addr;
               ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
               lookup_d = 1'b1;
            end
         end
         StLookup: begin
            if (cache_done) begin
               if (cache_hit) begin
                  state_d             = StResp;
                  resp_valid_d[idx_q] = 1'b1;
                  resp_hit_d          = 1'b1;
                  hit_d = (hit_q == {CNT_W{1'b1}}) ? hit_q : hit_q + CNT_W'(1);
               end else begin
                  state_d = StFill;
                  fill_d  = 1'b1;
                  miss_d  = (miss_q == {CNT_W{1'b1}}) ? miss_q : miss_q + CNT_W'(1);
               end
            end
         end
         StFill: begin
            if (fill_done) begin
               state_d             = StResp;
               resp_valid_d[idx_q] = 1'b1;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         idx_q        <= '0;
         addr_q       <= '0;
         lookup_q     <= 1'b0;
         fill_q       <= 1'b0;
         resp_valid_q <= '0;
         resp_hit_q   <= 1'b0;
         hit_q        <= '0;
         miss_q       <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         lookup_q     <= lookup_d;
         fill_q       <= fill_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
      end
   end

   assign resp_valid   = resp_valid_q;
   assign resp_hit     = resp_hit_q;
   assign cache_addr   = addr_q;
   assign cache_lookup = lookup_q;
   assign fill_start   = fill_q;
   assign hit_count    = hit_q;
   assign miss_count   = miss_q;

endmodule
